// File: rtl/wb_sdram_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of an SDRAM controller slave port.
// A stalled slave is detected by a no-ack timeout that reports err to the waiting master.
module wb_sdram_arbiter #(
  parameter int DW      = 32,
  parameter int AW      = 32,
  parameter int TIMEOUT = 256
) (
  input  logic            wb_clk_i,
  input  logic            RESETN,
  input  logic            sdr_init_done,

  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  input  logic            m0_we_i,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic [AW-1:0]   m0_addr_i,
  input  logic [DW-1:0]   m0_dat_i,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  output logic [DW-1:0]   m0_dat_o,

  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  input  logic            m1_we_i,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic [AW-1:0]   m1_addr_i,
  input  logic [DW-1:0]   m1_dat_i,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic [DW-1:0]   m1_dat_o,

  output logic            wb_cyc_o,
  output logic            wb_stb_o,
  output logic            wb_we_o,
  output logic [DW/8-1:0] wb_sel_o,
  output logic [AW-1:0]   wb_addr_o,
  output logic [DW-1:0]   wb_dat_o,
  input  logic            wb_ack_i,
  input  logic [DW-1:0]   wb_dat_i
);

  localparam int SW = DW / 8;
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    ERR   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t        state_reg, state_next;
  logic          grant_reg, grant_next;  // 0 selects m0, 1 selects m1
  logic          last_reg, last_next;
  logic [CW-1:0] tmo_reg, tmo_next;

  logic          g_cyc, g_stb, g_we;
  logic [SW-1:0] g_sel;
  logic [AW-1:0] g_addr;
  logic [DW-1:0] g_dat;

  assign g_cyc  = grant_reg ? m1_cyc_i  : m0_cyc_i;
  assign g_stb  = grant_reg ? m1_stb_i  : m0_stb_i;
  assign g_we   = grant_reg ? m1_we_i   : m0_we_i;
  assign g_sel  = grant_reg ? m1_sel_i  : m0_sel_i;
  assign g_addr = grant_reg ? m1_addr_i : m0_addr_i;
  assign g_dat  = grant_reg ? m1_dat_i  : m0_dat_i;

  always_ff @(posedge wb_clk_i or negedge RESETN) begin
    if (!RESETN) begin
      state_reg <= IDLE;
      grant_reg <= 1'b0;
      last_reg  <= 1'b1;
      tmo_reg   <= '0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      last_reg  <= last_next;
      tmo_reg   <= tmo_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    last_next  = last_reg;
    tmo_next   = '0;
    case (state_reg)
      IDLE: begin
        if (sdr_init_done && (m0_cyc_i || m1_cyc_i)) begin
          state_next = BUSY;
          // Under contention the master that did not win last time goes first.
          grant_next = (m0_cyc_i && m1_cyc_i) ? ~last_reg : m1_cyc_i;
          last_next  = grant_next;
        end
      end
      BUSY: begin
        if (!g_cyc) begin
          state_next = IDLE;
        end else if (g_stb && !wb_ack_i) begin
          if (tmo_reg == TMO_LAST) state_next = ERR;
          else                     tmo_next   = tmo_reg + 1'b1;
        end
      end
      ERR:     state_next = DRAIN;
      DRAIN:   if (!g_cyc) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    wb_cyc_o  = 1'b0;
    wb_stb_o  = 1'b0;
    wb_we_o   = 1'b0;
    wb_sel_o  = '0;
    wb_addr_o = '0;
    wb_dat_o  = '0;
    m0_ack_o  = 1'b0;
    m0_err_o  = 1'b0;
    m0_dat_o  = '0;
    m1_ack_o  = 1'b0;
    m1_err_o  = 1'b0;
    m1_dat_o  = '0;
    case (state_reg)
      BUSY: begin
        wb_cyc_o  = g_cyc;
        wb_stb_o  = g_stb;
        wb_we_o   = g_we;
        wb_sel_o  = g_sel;
        wb_addr_o = g_addr;
        wb_dat_o  = g_dat;
        if (grant_reg) begin
          m1_ack_o = wb_ack_i;
          m1_dat_o = wb_dat_i;
        end else begin
          m0_ack_o = wb_ack_i;
          m0_dat_o = wb_dat_i;
        end
      end
      ERR: begin
        if (grant_reg) m1_err_o = 1'b1;
        else           m0_err_o = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wb_sdram_arbiter.sv
// Bench for wb_sdram_arbiter: directed master traffic against a latency-by-address slave,
// with expected responses queued at issue and checked by an independent monitor.
`timescale 1ns/1ps
module tb_wb_sdram_arbiter;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int SW = DW / 8;
  localparam int TIMEOUT = 8;
  localparam logic [DW-1:0] KEY = 32'h5A5A_0F0F;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic init_done = 1'b0;

  logic [1:0]    m_cyc, m_stb, m_we;
  logic [SW-1:0] m_sel [2];
  logic [AW-1:0] m_addr [2];
  logic [DW-1:0] m_wdat [2];
  logic          m0_ack, m0_err, m1_ack, m1_err;
  logic [DW-1:0] m0_rdat, m1_rdat;
  logic [1:0]    m_ack, m_err;
  logic [DW-1:0] m_rdat [2];

  logic          wb_cyc, wb_stb, wb_we, wb_ack;
  logic [SW-1:0] wb_sel;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_wdat, wb_rdat;

  assign m_ack = {m1_ack, m0_ack};
  assign m_err = {m1_err, m0_err};
  assign m_rdat[0] = m0_rdat;
  assign m_rdat[1] = m1_rdat;

  wb_sdram_arbiter #(.DW(DW), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .wb_clk_i(clk), .RESETN(rst_n), .sdr_init_done(init_done),
    .m0_cyc_i(m_cyc[0]), .m0_stb_i(m_stb[0]), .m0_we_i(m_we[0]), .m0_sel_i(m_sel[0]),
    .m0_addr_i(m_addr[0]), .m0_dat_i(m_wdat[0]),
    .m0_ack_o(m0_ack), .m0_err_o(m0_err), .m0_dat_o(m0_rdat),
    .m1_cyc_i(m_cyc[1]), .m1_stb_i(m_stb[1]), .m1_we_i(m_we[1]), .m1_sel_i(m_sel[1]),
    .m1_addr_i(m_addr[1]), .m1_dat_i(m_wdat[1]),
    .m1_ack_o(m1_ack), .m1_err_o(m1_err), .m1_dat_o(m1_rdat),
    .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_we_o(wb_we), .wb_sel_o(wb_sel),
    .wb_addr_o(wb_addr), .wb_dat_o(wb_wdat), .wb_ack_i(wb_ack), .wb_dat_i(wb_rdat)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         name;
    int            id;
    bit            is_err;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdat;
    logic [DW-1:0] rdat;
    int            lat;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;
  int cyc_n = 0;
  int req_start [2];

  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Slave model: never acks 0xD------- addresses, otherwise acks after addr[19:16] wait cycles.
  int wait_cnt = 0;
  initial begin
    wb_ack = 1'b0;
    wb_rdat = '0;
    forever begin
      @(posedge clk);
      #2;
      wb_rdat = wb_addr ^ KEY;
      if (wb_cyc && wb_stb && wb_addr[31:28] != 4'hD) begin
        if (wait_cnt == int'(wb_addr[19:16])) begin
          wb_ack = 1'b1;
          wait_cnt = 0;
        end else begin
          wb_ack = 1'b0;
          wait_cnt++;
        end
      end else begin
        wb_ack = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  function automatic void expect_ack(string name, int id, logic [AW-1:0] addr,
                                     logic [DW-1:0] wdat, logic we, int lat);
    exp_t e;
    e.name = name; e.id = id; e.is_err = 1'b0; e.we = we;
    e.addr = addr; e.wdat = wdat; e.rdat = addr ^ KEY; e.lat = lat;
    sb.push_back(e);
  endfunction

  function automatic void expect_err(string name, int id, int lat);
    exp_t e;
    e.name = name; e.id = id; e.is_err = 1'b1; e.we = 1'b0;
    e.addr = '0; e.wdat = '0; e.rdat = '0; e.lat = lat;
    sb.push_back(e);
  endfunction

  function automatic bit outs_zero();
    return ({wb_cyc, wb_stb, wb_we, wb_sel, wb_addr, wb_wdat,
             m0_ack, m0_err, m0_rdat, m1_ack, m1_err, m1_rdat} == '0);
  endfunction

  task automatic check(string name, bit ok, logic [63:0] got, logic [63:0] want);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic check_event(input int id);
    exp_t e;
    int lat;
    int o;
    bit ok;
    o = 1 - id;
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $display("FAIL unexpected response: m%0d ack=%0b err=%0b at cycle %0d",
               id, m_ack[id], m_err[id], cyc_n);
      return;
    end
    e = sb.pop_front();
    lat = cyc_n - req_start[id];
    ok = (e.id == id) && (m_err[id] == e.is_err) && (m_ack[id] == !e.is_err) &&
         (m_rdat[id] == e.rdat) && (wb_cyc == !e.is_err) && (wb_we == e.we) &&
         (wb_addr == e.addr) && (wb_wdat == e.wdat) &&
         !m_ack[o] && !m_err[o] && (m_rdat[o] == '0) && (e.lat < 0 || lat == e.lat);
    if (!ok) begin
      miscompares++;
      $display("FAIL %s: got m%0d ack=%0b err=%0b rdat=%h addr=%h wdat=%h we=%0b lat=%0d other_ack=%0b; want m%0d err=%0b rdat=%h addr=%h wdat=%h we=%0b lat=%0d",
               e.name, id, m_ack[id], m_err[id], m_rdat[id], wb_addr, wb_wdat, wb_we, lat,
               m_ack[o], e.id, e.is_err, e.rdat, e.addr, e.wdat, e.we, e.lat);
    end else begin
      $display("txn %s: m%0d %s addr=%h rdat=%h lat=%0d", e.name, id,
               e.is_err ? "err" : "ack", wb_addr, m_rdat[id], lat);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++)
        if (m_ack[i] || m_err[i]) check_event(i);
    end
  end

  task automatic drop(input int id);
    m_cyc[id] = 1'b0; m_stb[id] = 1'b0; m_we[id] = 1'b0;
    m_sel[id] = '0; m_addr[id] = '0; m_wdat[id] = '0;
  endtask

  task automatic drive(input int id, input logic [AW-1:0] addr, input logic [DW-1:0] wdat,
                       input logic we);
    m_cyc[id] = 1'b1; m_stb[id] = 1'b1; m_we[id] = we;
    m_sel[id] = '1; m_addr[id] = addr; m_wdat[id] = wdat;
    req_start[id] = cyc_n;
  endtask

  // One master cycle of 'beats' beats; after an err, cyc is held 'hold' cycles before dropping.
  task automatic master_txn(input int id, input logic [AW-1:0] addr, input logic [DW-1:0] wdat,
                            input logic we, input int beats, input int hold);
    int waited;
    @(posedge clk); #1;
    drive(id, addr, wdat, we);
    for (int b = 0; b < beats; b++) begin
      waited = 0;
      @(negedge clk);
      while (!m_ack[id] && !m_err[id] && waited < 200) begin
        @(negedge clk);
        waited++;
      end
      if (!m_ack[id] && !m_err[id]) begin
        vectors++;
        miscompares++;
        $display("FAIL m%0d response wait: got none after %0d cycles want ack or err", id, waited);
        break;
      end
      if (m_err[id]) begin
        repeat (hold - 1) @(posedge clk);
        break;
      end
      if (b < beats - 1) begin
        @(posedge clk); #1;
        m_addr[id] = m_addr[id] + 4;
        m_wdat[id] = m_wdat[id] + 1;
      end
    end
    @(posedge clk); #1;
    drop(id);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit seen;
    drop(0);
    drop(1);
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", outs_zero(), {63'd0, wb_cyc}, 64'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Grants are blocked until the controller reports init complete.
    #1;
    drive(0, 32'h0000_1240, 32'hCAFE_0001, 1'b1);
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (wb_cyc) seen = 1'b1;
    end
    check("init_block", !seen, {63'd0, seen}, 64'd0);
    @(posedge clk); #1;
    init_done = 1'b1;
    req_start[0] = cyc_n;
    expect_ack("init_release", 0, 32'h0000_1240, 32'hCAFE_0001, 1'b1, 1);
    @(negedge clk);
    @(negedge clk);
    check("init_cyc", wb_cyc == 1'b1, {63'd0, wb_cyc}, 64'd1);
    check("init_addr", wb_addr == 32'h0000_1240, {32'd0, wb_addr}, 64'h1240);
    @(posedge clk); #1;
    drop(0);
    repeat (3) @(posedge clk);

    // Latency 2 read, then a latency 7 write acked with the counter at TIMEOUT-1.
    expect_ack("m0_lat2", 0, 32'h0002_2000, 32'h1111_0000, 1'b0, 3);
    master_txn(0, 32'h0002_2000, 32'h1111_0000, 1'b0, 1, 1);
    expect_ack("m1_lat7_edge", 1, 32'h0007_3000, 32'h2222_0000, 1'b1, 8);
    master_txn(1, 32'h0007_3000, 32'h2222_0000, 1'b1, 1, 1);
    repeat (3) @(posedge clk);

    // Continuous contention alternates grants m0,m1,m0,m1 with an IDLE cycle between.
    for (int i = 0; i < 4; i++) begin
      expect_ack("alt_m0", 0, 32'h0000_4000 + 32'(i * 16), 32'hA000_0000 + 32'(i), 1'b1, (i == 0) ? 1 : 4);
      expect_ack("alt_m1", 1, 32'h0000_5000 + 32'(i * 16), 32'hA100_0000 + 32'(i), 1'b1, 4);
    end
    fork
      for (int i = 0; i < 4; i++) master_txn(0, 32'h0000_4000 + 32'(i * 16), 32'hA000_0000 + 32'(i), 1'b1, 1, 1);
      for (int j = 0; j < 4; j++) master_txn(1, 32'h0000_5000 + 32'(j * 16), 32'hA100_0000 + 32'(j), 1'b1, 1, 1);
    join
    repeat (3) @(posedge clk);

    // m1 holds an 8-beat burst; m0 waits until m1 drops cyc.
    for (int i = 0; i < 8; i++)
      expect_ack("burst_m1", 1, 32'h0000_6000 + 32'(i * 4), 32'hB000_0000 + 32'(i), 1'b1, (i == 0) ? 1 : -1);
    expect_ack("after_burst_m0", 0, 32'h0000_7000, 32'hC000_0000, 1'b0, 9);
    fork
      master_txn(1, 32'h0000_6000, 32'hB000_0000, 1'b1, 8, 1);
      begin
        repeat (2) @(posedge clk);
        master_txn(0, 32'h0000_7000, 32'hC000_0000, 1'b0, 1, 1);
      end
    join
    repeat (3) @(posedge clk);

    // Dead slave: m0 times out, holds cyc through DRAIN, then m1 is served.
    expect_err("timeout_m0", 0, 9);
    expect_ack("after_err_m1", 1, 32'h0000_9000, 32'hE000_0000, 1'b0, 12);
    fork
      master_txn(0, 32'hD000_8000, 32'hD00D_0000, 1'b1, 1, 3);
      begin
        repeat (2) @(posedge clk);
        master_txn(1, 32'h0000_9000, 32'hE000_0000, 1'b0, 1, 1);
      end
    join
    repeat (3) @(posedge clk);

    // Reset mid-burst from m0, then contention must again go to m0 first.
    for (int i = 0; i < 3; i++)
      expect_ack("pre_reset_m0", 0, 32'h0000_A000, 32'hF000_0000, 1'b1, i + 1);
    @(posedge clk); #1;
    drive(0, 32'h0000_A000, 32'hF000_0000, 1'b1);
    repeat (4) @(negedge clk);
    #2;
    check("pre_reset_busy", wb_cyc == 1'b1, {63'd0, wb_cyc}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", outs_zero(), {wb_addr, 31'd0, wb_cyc}, 64'd0);
    @(posedge clk); #1;
    drop(0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_idle", outs_zero(), {62'd0, m0_ack, wb_cyc}, 64'd0);
    repeat (2) @(posedge clk);
    expect_ack("post_reset_m0", 0, 32'h0000_B000, 32'h0B0B_0000, 1'b0, 1);
    expect_ack("post_reset_m1", 1, 32'h0000_C000, 32'h0C0C_0000, 1'b1, 4);
    fork
      master_txn(0, 32'h0000_B000, 32'h0B0B_0000, 1'b0, 1, 1);
      master_txn(1, 32'h0000_C000, 32'h0C0C_0000, 1'b1, 1, 1);
    join
    repeat (5) @(posedge clk);

    check("scoreboard_drained", sb.size() == 0, 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
